// File: rtl/lv8_ctrl_pkg.sv
// Shared LEGv8 control-unit definitions: control-word layout, FSM states,
// branch opcodes and the branch-class decode helper.
package lv8_ctrl_pkg;

  localparam int unsigned CW_WIDTH = 33;

  localparam int unsigned CW_ALU_EN      = 32;
  localparam int unsigned CW_ALU_B_SEL   = 31;
  localparam int unsigned CW_ALU_FS      = 26;
  localparam int unsigned CW_RF_B_EN     = 25;
  localparam int unsigned CW_SA          = 20;
  localparam int unsigned CW_SB          = 15;
  localparam int unsigned CW_DA          = 10;
  localparam int unsigned CW_RF_WRITE    = 9;
  localparam int unsigned CW_RAM_EN      = 8;
  localparam int unsigned CW_RAM_WRITE   = 7;
  localparam int unsigned CW_PC_EN       = 6;
  localparam int unsigned CW_PC_FS       = 4;
  localparam int unsigned CW_PC_IN_SEL   = 3;
  localparam int unsigned CW_STATUS_LOAD = 2;
  localparam int unsigned CW_NEXT_STATE  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LINK = 2'b01,
    ST_TEST = 2'b10,
    ST_EXEC = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_INC  = 2'b01,
    PC_REG  = 2'b10,
    PC_REL  = 2'b11
  } pc_fs_e;

  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [5:0]  OP_BL    = 6'b100101;
  localparam logic [10:0] OP_BR    = 11'b11010110000;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;

  localparam logic [4:0] ALU_PASS_B = 5'b00111;

  typedef enum logic [2:0] {
    BK_NONE,
    BK_B,
    BK_BL,
    BK_BR,
    BK_CBZ,
    BK_CBNZ,
    BK_BCOND
  } br_kind_e;

  function automatic br_kind_e decode_branch(input logic [31:0] instr);
    br_kind_e kind;
    kind = BK_NONE;
    if (instr[31:26] == OP_B)          kind = BK_B;
    else if (instr[31:26] == OP_BL)    kind = BK_BL;
    else if (instr[31:21] == OP_BR)    kind = BK_BR;
    else if (instr[31:24] == OP_CBZ)   kind = BK_CBZ;
    else if (instr[31:24] == OP_CBNZ)  kind = BK_CBNZ;
    else if (instr[31:24] == OP_BCOND) kind = BK_BCOND;
    return kind;
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational B.cond evaluator: condition code and stored {V,C,N,Z} to taken.
module branch_cond_eval (
  input  logic [3:0] cond_i,
  input  logic [3:0] flags_i,
  output logic       taken_o
);
  logic v, c, n, z;
  logic base;

  assign {v, c, n, z} = flags_i;

  // Even codes test a predicate, odd codes its inverse; 111x is always taken.
  always_comb begin
    base = 1'b1;
    case (cond_i[3:1])
      3'b000:  base = z;
      3'b001:  base = c;
      3'b010:  base = n;
      3'b011:  base = v;
      3'b100:  base = c & ~z;
      3'b101:  base = (n == v);
      3'b110:  base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    taken_o = (cond_i[3:1] == 3'b111) ? 1'b1 : (base ^ cond_i[0]);
  end

endmodule

// File: rtl/branch_sequencer.sv
// Branch-class sequencer for the LEGv8 control unit: IDLE -> (LINK|TEST) -> EXEC,
// driving the shared control word and immediate, with saturating outcome counters.
module branch_sequencer
  import lv8_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned LINK_REG   = 30
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           instruction,
  input  logic [4:0]            status,
  output logic [CW_WIDTH-1:0]   controlword,
  output logic [DATA_WIDTH-1:0] constant,
  output logic                  busy,
  output logic                  done,
  output logic                  taken,
  output logic                  illegal,
  output logic [CNT_WIDTH-1:0]  taken_count,
  output logic [CNT_WIDTH-1:0]  not_taken_count
);

  state_e               state_q, state_d;
  logic [31:0]          instr_q;
  logic                 cb_zero_q;
  logic                 illegal_q;
  logic [CNT_WIDTH-1:0] taken_cnt_q, not_taken_cnt_q;
  br_kind_e             kind_in, kind_q;
  logic                 cond_taken;
  logic                 taken_c;
  logic                 start_legal;
  logic [CW_WIDTH-1:0]  cw;

  assign kind_in     = decode_branch(instruction);
  assign kind_q      = decode_branch(instr_q);
  assign start_legal = (state_q == ST_IDLE) && start && (kind_in != BK_NONE);

  branch_cond_eval u_cond_eval (
    .cond_i  (instr_q[3:0]),
    .flags_i (status[3:0]),
    .taken_o (cond_taken)
  );

  // Next state and the EXEC-cycle branch decision.
  always_comb begin
    state_d = state_q;
    taken_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (kind_in)
            BK_BL:                 state_d = ST_LINK;
            BK_CBZ, BK_CBNZ:       state_d = ST_TEST;
            BK_B, BK_BR, BK_BCOND: state_d = ST_EXEC;
            default:               state_d = ST_IDLE;
          endcase
        end
      end
      ST_LINK, ST_TEST: state_d = ST_EXEC;
      default: begin
        state_d = ST_IDLE;
        case (kind_q)
          BK_B, BK_BL, BK_BR: taken_c = 1'b1;
          BK_CBZ:             taken_c = cb_zero_q;
          BK_CBNZ:            taken_c = ~cb_zero_q;
          BK_BCOND:           taken_c = cond_taken;
          default:            taken_c = 1'b0;
        endcase
      end
    endcase
  end

  // Control word for the current state; next_state mirrors the state register input.
  always_comb begin
    cw = '0;
    // Branches never enable the ALU, memory or flag load, so flags stay stable.
    cw[CW_ALU_EN]      = 1'b0;
    cw[CW_RF_B_EN]     = 1'b0;
    cw[CW_RAM_EN]      = 1'b0;
    cw[CW_RAM_WRITE]   = 1'b0;
    cw[CW_STATUS_LOAD] = 1'b0;
    case (state_q)
      ST_LINK: begin
        cw[CW_PC_EN]       = 1'b1;
        cw[CW_DA +: 5]     = 5'(LINK_REG);
        cw[CW_RF_WRITE]    = 1'b1;
        cw[CW_PC_FS +: 2]  = PC_HOLD;
      end
      ST_TEST: begin
        cw[CW_SB +: 5]     = instr_q[4:0];
        cw[CW_ALU_B_SEL]   = 1'b0;
        cw[CW_ALU_FS +: 5] = ALU_PASS_B;
      end
      ST_EXEC: begin
        if (!taken_c) begin
          cw[CW_PC_FS +: 2] = PC_INC;
        end else if (kind_q == BK_BR) begin
          cw[CW_PC_FS +: 2] = PC_REG;
          cw[CW_PC_IN_SEL]  = 1'b0;
          cw[CW_SA +: 5]    = instr_q[9:5];
        end else begin
          cw[CW_PC_FS +: 2] = PC_REL;
          cw[CW_PC_IN_SEL]  = 1'b1;
        end
      end
      default: cw = '0;
    endcase
    cw[CW_NEXT_STATE +: 2] = state_d;
  end

  always_comb begin
    case (kind_q)
      BK_B, BK_BL:               constant = {{(DATA_WIDTH-26){instr_q[25]}}, instr_q[25:0]};
      BK_CBZ, BK_CBNZ, BK_BCOND: constant = {{(DATA_WIDTH-19){instr_q[23]}}, instr_q[23:5]};
      default:                   constant = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      instr_q         <= '0;
      cb_zero_q       <= 1'b0;
      illegal_q       <= 1'b0;
      taken_cnt_q     <= '0;
      not_taken_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= (state_q == ST_IDLE) && start && (kind_in == BK_NONE);
      if (start_legal) instr_q <= instruction;
      if (state_q == ST_TEST) cb_zero_q <= status[4];
      if (state_q == ST_EXEC) begin
        if (taken_c) begin
          if (taken_cnt_q != '1) taken_cnt_q <= taken_cnt_q + CNT_WIDTH'(1);
        end else begin
          if (not_taken_cnt_q != '1) not_taken_cnt_q <= not_taken_cnt_q + CNT_WIDTH'(1);
        end
      end
    end
  end

  assign controlword     = cw;
  assign busy            = (state_q != ST_IDLE);
  assign done            = (state_q == ST_EXEC);
  assign taken           = taken_c;
  assign illegal         = illegal_q;
  assign taken_count     = taken_cnt_q;
  assign not_taken_count = not_taken_cnt_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed, table-driven bench for branch_sequencer with hand-computed expectations.
module tb_branch_sequencer;

  localparam int unsigned CNTW = 4;
  localparam int          CMAX = 15;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] instruction;
  logic [4:0]  status;
  logic [32:0] controlword;
  logic [63:0] constant;
  logic        busy, done, taken, illegal;
  logic [CNTW-1:0] taken_count, not_taken_count;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_tk   = 0;
  int exp_nt   = 0;

  branch_sequencer #(.DATA_WIDTH(64), .CNT_WIDTH(CNTW), .LINK_REG(30)) dut (
    .clock           (clock),
    .reset           (reset),
    .start           (start),
    .instruction     (instruction),
    .status          (status),
    .controlword     (controlword),
    .constant        (constant),
    .busy            (busy),
    .done            (done),
    .taken           (taken),
    .illegal         (illegal),
    .taken_count     (taken_count),
    .not_taken_count (not_taken_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [32:0] mk_cw(input logic [4:0] alu_fs, input logic [4:0] sa,
                                        input logic [4:0] sb, input logic [4:0] da,
                                        input logic rf_write, input logic pc_en,
                                        input logic [1:0] pc_fs, input logic pc_in_sel,
                                        input logic [1:0] ns);
    return {1'b0, 1'b0, alu_fs, 1'b0, sa, sb, da, rf_write, 1'b0, 1'b0, pc_en, pc_fs,
            pc_in_sel, 1'b0, ns};
  endfunction

  function automatic logic [32:0] mid_word(input logic [1:0] ns, input logic [31:0] ins);
    if (ns == 2'b01) return mk_cw(5'd0, 5'd0, 5'd0, 5'd30, 1'b1, 1'b1, 2'b00, 1'b0, 2'b11);
    return mk_cw(lv8_ctrl_pkg::ALU_PASS_B, 5'd0, ins[4:0], 5'd0, 1'b0, 1'b0, 2'b00, 1'b0, 2'b11);
  endfunction

  function automatic logic [32:0] exec_word(input logic tk, input logic is_br, input logic [31:0] ins);
    if (!tk) return mk_cw(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b01, 1'b0, 2'b00);
    if (is_br) return mk_cw(5'd0, ins[9:5], 5'd0, 5'd0, 1'b0, 1'b0, 2'b10, 1'b0, 2'b00);
    return mk_cw(5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 2'b11, 1'b1, 2'b00);
  endfunction

  task automatic model_count(input logic tk);
    if (tk) begin
      if (exp_tk < CMAX) exp_tk++;
    end else begin
      if (exp_nt < CMAX) exp_nt++;
    end
  endtask

  // One full branch: start cycle, optional LINK/TEST cycle, EXEC, then the idle cycle.
  task automatic run_branch(input string name, input logic [31:0] ins, input logic [4:0] st,
                            input logic [1:0] first_ns, input logic tk, input logic is_br,
                            input logic [63:0] cst);
    @(negedge clock);
    instruction = ins; status = st; start = 1'b1;
    #1;
    check({name, " start_ns"}, 64'(controlword), 64'({31'b0, first_ns}));
    @(negedge clock);
    start = 1'b0;
    #1;
    if (first_ns != 2'b11) begin
      check({name, " mid_word"}, 64'(controlword), 64'(mid_word(first_ns, ins)));
      check({name, " mid_done"}, 64'(done), 64'(1'b0));
      check({name, " mid_busy"}, 64'(busy), 64'(1'b1));
      @(negedge clock);
      #1;
    end
    check({name, " exec_word"}, 64'(controlword), 64'(exec_word(tk, is_br, ins)));
    check({name, " exec_done"}, 64'(done), 64'(1'b1));
    check({name, " taken"}, 64'(taken), 64'(tk));
    check({name, " constant"}, constant, cst);
    model_count(tk);
    @(negedge clock);
    #1;
    check({name, " idle_busy"}, 64'(busy), 64'(1'b0));
    check({name, " idle_done"}, 64'(done), 64'(1'b0));
    check({name, " taken_count"}, 64'(taken_count), 64'(exp_tk));
    check({name, " not_taken_count"}, 64'(not_taken_count), 64'(exp_nt));
  endtask

  typedef struct {
    logic [31:0] ins;
    logic [4:0]  st;
    logic [1:0]  ns;
    logic        tk;
    logic        br;
    logic [63:0] cst;
  } vec_t;

  vec_t        vecs[9];
  logic [4:0]  sweep_st[3];
  logic [15:0] sweep_mask[3];

  initial begin
    vecs[0] = '{32'h17FF_FFFF, 5'b00000, 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}; // B -1
    vecs[1] = '{32'h9400_0004, 5'b00000, 2'b01, 1'b1, 1'b0, 64'h4};                   // BL +4
    vecs[2] = '{32'hB500_0205, 5'b10000, 2'b10, 1'b0, 1'b0, 64'h10};                  // CBNZ X5, zero
    vecs[3] = '{32'hB4FF_FFE7, 5'b10000, 2'b10, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF}; // CBZ X7, zero
    vecs[4] = '{32'hB400_0103, 5'b00000, 2'b10, 1'b0, 1'b0, 64'h8};                   // CBZ X3, nonzero
    vecs[5] = '{32'hB500_0029, 5'b00000, 2'b10, 1'b1, 1'b0, 64'h1};                   // CBNZ X9, nonzero
    vecs[6] = '{32'hD61F_0180, 5'b00000, 2'b11, 1'b1, 1'b1, 64'h0};                   // BR X12
    vecs[7] = '{32'h1600_0000, 5'b00000, 2'b11, 1'b1, 1'b0, 64'hFFFF_FFFF_FE00_0000}; // B min
    vecs[8] = '{32'h95FF_FFFF, 5'b00000, 2'b01, 1'b1, 1'b0, 64'h0000_0000_01FF_FFFF}; // BL max

    // status = {zero, V, C, N, Z}; mask bit i = expected taken for condition i
    sweep_st[0] = 5'b00101; sweep_mask[0] = 16'b1110_0110_1010_0101; // Z=1 C=1 N=0 V=0
    sweep_st[1] = 5'b00010; sweep_mask[1] = 16'b1110_1010_1001_1010; // N=1 V=0 (GE not taken)
    sweep_st[2] = 5'b01110; sweep_mask[2] = 16'b1101_0101_0101_0110; // V=C=N=1 Z=0 (GT taken)

    reset = 1'b1; start = 1'b0; instruction = 32'h0; status = 5'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst controlword", 64'(controlword), 64'h0);
    check("rst busy", 64'(busy), 64'h0);
    check("rst done", 64'(done), 64'h0);
    check("rst illegal", 64'(illegal), 64'h0);
    check("rst constant", constant, 64'h0);
    check("rst taken_count", 64'(taken_count), 64'h0);
    check("rst not_taken_count", 64'(not_taken_count), 64'h0);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_branch($sformatf("vec%0d", i), vecs[i].ins, vecs[i].st, vecs[i].ns, vecs[i].tk,
                 vecs[i].br, vecs[i].cst);

    // Illegal opcode: one-cycle pulse, no state change.
    @(negedge clock);
    instruction = 32'h8B00_0000; start = 1'b1;
    #1;
    check("illegal start_ns", 64'(controlword), 64'h0);
    @(negedge clock);
    start = 1'b0;
    #1;
    check("illegal pulse", 64'(illegal), 64'h1);
    check("illegal busy", 64'(busy), 64'h0);
    check("illegal cw", 64'(controlword), 64'h0);
    @(negedge clock);
    #1;
    check("illegal clear", 64'(illegal), 64'h0);
    check("illegal taken_count", 64'(taken_count), 64'(exp_tk));
    check("illegal not_taken_count", 64'(not_taken_count), 64'(exp_nt));

    // Start during LINK is ignored.
    @(negedge clock);
    instruction = 32'h9400_0004; status = 5'b0; start = 1'b1;
    @(negedge clock);
    instruction = 32'h1400_0010;
    #1;
    check("ignore link_word", 64'(controlword), 64'(mid_word(2'b01, 32'h0)));
    @(negedge clock);
    start = 1'b0;
    #1;
    check("ignore exec_word", 64'(controlword), 64'(exec_word(1'b1, 1'b0, 32'h0)));
    check("ignore constant", constant, 64'h4);
    check("ignore done", 64'(done), 64'h1);
    model_count(1'b1);
    @(negedge clock);
    #1;
    check("ignore idle_busy", 64'(busy), 64'h0);
    @(negedge clock);
    #1;
    check("ignore no_second_done", 64'(done), 64'h0);
    check("ignore no_second_busy", 64'(busy), 64'h0);
    check("ignore taken_count", 64'(taken_count), 64'(exp_tk));

    for (int s = 0; s < 3; s++)
      for (int c = 0; c < 16; c++)
        run_branch($sformatf("bcond s%0d c%0d", s, c), 32'h54FF_FFC0 | 32'(c), sweep_st[s],
                   2'b11, sweep_mask[s][c], 1'b0, 64'hFFFF_FFFF_FFFF_FFFE);

    // Both counters are saturated by now; another taken branch must hold at all-ones.
    check("sat pre taken_count", 64'(taken_count), 64'hF);
    check("sat pre not_taken_count", 64'(not_taken_count), 64'hF);
    run_branch("sat B", 32'h1400_0001, 5'b0, 2'b11, 1'b1, 1'b0, 64'h1);
    check("sat taken_count", 64'(taken_count), 64'hF);

    // Reset while in TEST aborts the sequence.
    @(negedge clock);
    instruction = 32'hB400_0103; status = 5'b10000; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    #1;
    check("abort test_word", 64'(controlword), 64'(mid_word(2'b10, 32'hB400_0103)));
    reset = 1'b1;
    #1;
    check("abort busy", 64'(busy), 64'h0);
    check("abort cw", 64'(controlword), 64'h0);
    check("abort done", 64'(done), 64'h0);
    check("abort taken_count", 64'(taken_count), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("abort post done", 64'(done), 64'h0);
    @(negedge clock);
    #1;
    check("abort post2 done", 64'(done), 64'h0);
    check("abort post2 busy", 64'(busy), 64'h0);
    check("abort not_taken_count", 64'(not_taken_count), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Multi-cycle branch controller for the LEGv8 control unit. It decodes B, BL, BR, CBZ, CBNZ and B.cond, owns its own state register, and drives the same 33-bit control word and immediate `constant` as the other instruction-class decoders. It also keeps saturating taken and not-taken counters. It sits beside the other class decoders, selected by the opcode dispatcher, and feeds the control-word mux.

## Interface
- `DATA_WIDTH`, default 64: width of `constant`.
- `CNT_WIDTH`, default 16: width of each statistics counter.
- `LINK_REG`, default 30: register written by BL.
- `clock`, in, 1: sole clock.
- `reset`, in, 1: asynchronous, active-high.
- `start`, in, 1: dispatcher hands over `instruction`. Sampled only in IDLE.
- `instruction`, in, 32: raw instruction. Latched on an accepted `start`.
- `status`, in, 5: {live ALU zero, V, C, N, Z}. Bits [3:0] are the stored flags.
- `controlword`, out, 33: fields from MSB to LSB:
  - alu_en, alu_b_sel, alu_fs[5], rf_b_en, sa[5], sb[5], da[5], rf_write;
  - ram_en, ram_write, pc_en, pc_fs[2], pc_in_sel, status_load, next_state[2].
- `constant`, out, DATA_WIDTH: sign-extended immediate of the latched instruction.
- `busy`, out, 1: high in any state except IDLE.
- `done`, out, 1: one-cycle pulse in EXEC.
- `taken`, out, 1: branch decision. Valid while `done` is high.
- `illegal`, out, 1: one-cycle pulse after `start` with a non-branch opcode.
- `taken_count`, out, CNT_WIDTH: number of completed taken branches.
- `not_taken_count`, out, CNT_WIDTH: number of completed not-taken branches.

## Operation
- Opcode decode:
  - B: [31:26]=000101.
  - BL: [31:26]=100101.
  - BR: [31:21]=11010110000. Rn is [9:5].
  - CBZ: [31:24]=10110100. CBNZ: [31:24]=10110101. Rt is [4:0].
  - B.cond: [31:24]=01010100. Condition is [3:0].
- Immediate:
  - B and BL: `constant` = sign-extend of [25:0].
  - CBZ, CBNZ and B.cond: `constant` = sign-extend of [23:5].
  - BR: `constant` = 0.
- States: IDLE=00, LINK=01, TEST=10, EXEC=11.
- Transitions:
  - IDLE to LINK on an accepted `start` with BL.
  - IDLE to TEST on an accepted `start` with CBZ or CBNZ.
  - IDLE to EXEC on an accepted `start` with B, BR or B.cond.
  - IDLE stays IDLE on `start` with an illegal opcode.
  - LINK to EXEC. TEST to EXEC. EXEC to IDLE.
- The `next_state` field of `controlword` always equals the registered state of the following cycle.
- Control-word fields not listed below are 0.
- IDLE word: all zero except `next_state`.
- LINK word: pc_en=1, da=LINK_REG, rf_write=1, pc_fs=00 (hold). This stores PC+4 in the link register.
- TEST word: sb=Rt, alu_b_sel=0, alu_fs=ALU_PASS_B. `status[4]` is registered at the end of TEST as `cb_zero`.
- EXEC word when taken:
  - BR: pc_fs=10, pc_in_sel=0, sa=Rn.
  - All other branches: pc_fs=11, pc_in_sel=1 (PC + constant*4).
- EXEC word when not taken: pc_fs=01 (PC+4).
- Decision (combinational in EXEC):
  - B, BL, BR: always taken.
  - CBZ: taken = `cb_zero`. CBNZ: taken = !`cb_zero`.
  - B.cond evaluates `status[3:0]`:
    - EQ: Z. NE: !Z.
    - CS: C. CC: !C.
    - MI: N. PL: !N.
    - VS: V. VC: !V.
    - HI: C&!Z. LS: !(C&!Z).
    - GE: N==V. LT: N!=V.
    - GT: !Z&(N==V). LE: the inverse of GT.
    - 1110 and 1111: always taken.
- `status_load` is 0 in every state, so flags stay stable across the sequence.
- Counters increment at the end of EXEC according to `taken`, and saturate at all-ones.

## Timing
- Reset values: state=IDLE, `controlword`=0, `busy`=0, `done`=0, `taken`=0, `illegal`=0, both counters 0, latched instruction 0, hence `constant`=0.
- Reset asserted mid-sequence aborts it immediately. No `done` pulse follows and the counters are not incremented.
- Latency, with `start` at cycle t:
  - B, BR, B.cond: EXEC and `done` at t+1.
  - BL, CBZ, CBNZ: EXEC and `done` at t+2.
  - A new `start` is accepted in the cycle after EXEC.
- `start` while `busy` is ignored. It is not queued and not flagged.
- `illegal` pulses at t+1. State and counters are unchanged.

## Structure
- Shared package `lv8_ctrl_pkg`:
  - control-word field offsets;
  - state encodings;
  - opcode constants;
  - `ALU_PASS_B`;
  - pc_fs codes: HOLD=00, INC=01, REG=10, REL=11.
- Sub-module `branch_cond_eval`: combinational evaluation of (cond[3:0], flags[3:0]) to taken.

## Test plan
- B with imm26=0x3FFFFFF: `start` at t → EXEC at t+1, pc_fs=11, `constant`=-1, `done`=1, `taken_count`=1.
- BL with imm26=4: LINK at t+1 (da=30, rf_write=1) → EXEC at t+2 (pc_fs=11) → IDLE at t+3.
- CBNZ X5 with `status[4]`=1 during TEST: TEST word sb=5 → EXEC pc_fs=01, `taken`=0, `not_taken_count`=1.
- B.cond GE with N=1, V=0 → not taken. GT with Z=0, N=V=1 → taken. Sweep all 16 condition codes.
- Illegal opcode 0x8B000000 → `illegal` pulse at t+1, state stays IDLE. A second `start` during BL's LINK state is ignored.
- Preload `taken_count` to all-ones and issue B → count holds at all-ones. Reset during TEST → immediate IDLE, `controlword`=0, no `done`.
